zone_bank_scheduler: RTL and testbench
======================================

ZONE_BANK_SCHEDULER -- requirements
Module: zone_bank_scheduler

Interface
REQ-001 SHALL have parameter N_ZONE, default 360: number of LED zones per frame.
REQ-002 SHALL have parameter GAIN_MIN, default 32: lower clamp of the ambient gain.
REQ-003 SHALL have port I_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port I_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port I_wr_en, input, 1: zone write strobe from the statistics engine.
REQ-006 SHALL have port I_wr_addr, input, 9: zone index to write.
REQ-007 SHALL have port I_wr_data, input, 8: zone gray level to write.
REQ-008 SHALL have port I_wr_frame_done, input, 1: one-cycle pulse, writer finished a frame.
REQ-009 SHALL have port I_rd_req, input, 1: LED driver read request.
REQ-010 SHALL have port I_rd_addr, input, 9: zone index to read.
REQ-011 SHALL have port I_rd_frame_done, input, 1: one-cycle pulse, driver finished a refresh.
REQ-012 SHALL have port I_bright_data, input, 12: ambient light level, already synchronous to I_clk.
REQ-013 SHALL have port O_rd_valid, output, 1: read data valid.
REQ-014 SHALL have port O_rd_data, output, 8: gain-scaled zone level.
REQ-015 SHALL have port O_wr_bank, output, 1: bank currently owned by the writer.
REQ-016 SHALL have port O_rd_bank, output, 1: bank currently owned by the reader.
REQ-017 SHALL have port O_swap, output, 1: one-cycle pulse marking a bank swap.
REQ-018 SHALL have port O_drop_cnt, output, 8: saturating count of dropped writer frames.
REQ-019 SHALL have port O_state, output, 2: current FSM state, for debug.

Function
REQ-020 SHALL store frames in two banks of N_ZONE x 8 bits, used ping-pong.
REQ-021 SHALL keep O_wr_bank equal to !O_rd_bank at all times.
REQ-022 SHALL write I_wr_data to the write bank at I_wr_addr on I_wr_en when I_wr_addr < N_ZONE, and SHALL ignore the write otherwise.
REQ-023 SHALL assert O_rd_valid exactly 2 cycles after I_rd_req: cycle 1 registered RAM read, cycle 2 registered scale; back-to-back requests fully pipelined.
REQ-024 SHALL compute O_rd_data = min(255, (zone * gain) >> 7), using a 16-bit product.
REQ-025 SHALL return O_rd_data = 0 when I_rd_addr >= N_ZONE or the state is IDLE; O_rd_valid still pulses.
REQ-026 SHALL derive gain as max(GAIN_MIN, I_bright_data[11:4]).
REQ-027 SHALL latch gain only in the swap cycle, so gain is constant within a reader frame.
REQ-028 SHALL implement FSM states IDLE=0, RUN=1, WAIT_RD=2, WAIT_WR=3.
REQ-029 IDLE: wr_frame_done SHALL cause a swap and go to RUN; rd_frame_done SHALL be ignored.
REQ-030 RUN: wr_frame_done alone SHALL go to WAIT_RD; rd_frame_done alone SHALL go to WAIT_WR; both in the same cycle SHALL cause a swap and stay in RUN.
REQ-031 WAIT_RD: rd_frame_done SHALL cause a swap and go to RUN; wr_frame_done SHALL drop that frame (O_drop_cnt +1, saturating at 255, writer keeps its bank) and stay in WAIT_RD; both in the same cycle SHALL cause a swap and go to RUN with no drop.
REQ-032 WAIT_WR: wr_frame_done SHALL cause a swap and go to RUN; rd_frame_done SHALL be ignored and stay in WAIT_WR.
REQ-033 A swap SHALL toggle both bank bits and pulse O_swap on the cycle after the triggering event.
REQ-034 Reads in flight across a swap SHALL complete from the bank that was sampled at I_rd_req.
REQ-035 A write in the same cycle as a swap trigger SHALL land in the old write bank.

Reset
REQ-036 On I_rst: state=IDLE, wr_bank=0, rd_bank=1, gain=128, O_rd_valid=0, O_rd_data=0, O_swap=0, O_drop_cnt=0, read pipeline cleared.
REQ-037 Bank RAM contents SHALL NOT be reset; IDLE masking (REQ-025) hides stale data.
REQ-038 Reset mid-frame SHALL abandon the frame; the next wr_frame_done SHALL be treated as the first frame.

Structure
REQ-039 A shared package SHALL hold N_ZONE, GAIN_MIN, the FSM state encodings and the zone address width (9).
REQ-040 The bank RAM SHALL be one sub-module, zone_dpram: simple dual-port, 2*N_ZONE x 8, bank bit as address MSB, registered read.

Verification
REQ-041 After reset, wr_frame_done -> O_swap pulses next cycle, rd_bank=0, state=RUN, gain latched.
REQ-042 Write zone 5=200, bright=0x800 (gain 128), swap, read addr 5 -> O_rd_valid 2 cycles later, data=200; bright=0xFFF (gain 255) at next swap -> data=255 (saturated).
REQ-043 From RUN: wr_done, then two more wr_done before rd_done -> O_drop_cnt=2, a single swap on rd_done.
REQ-044 wr_frame_done and rd_frame_done in the same cycle in RUN -> one swap, state stays RUN, no drop.
REQ-045 Read addr 360, write addr 400 -> rd_data=0, RAM contents unchanged; bright=0x010 -> gain clamps to 32.

Source files
------------

// File: rtl/zone_bank_scheduler_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the zone bank scheduler.
package zone_bank_scheduler_pkg;

  localparam int unsigned ZBS_N_ZONE   = 360;
  localparam int unsigned ZBS_GAIN_MIN = 32;
  localparam int unsigned ZBS_ADDR_W   = 9;
  localparam logic [7:0]  ZBS_GAIN_RST = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } zbs_state_e;

  // Ambient gain: upper byte of the brightness level, floored at gmin.
  function automatic logic [7:0] gain_clamp(input logic [11:0] bright, input logic [7:0] gmin);
    logic [7:0] lvl;
    lvl = 8'(bright >> 4);
    return (lvl < gmin) ? gmin : lvl;
  endfunction

  // Zone level scaled by gain/128, saturated to 8 bits.
  function automatic logic [7:0] zone_scale(input logic [7:0] zone, input logic [7:0] gain);
    logic [15:0] prod;
    logic [15:0] shr;
    prod = 16'(zone) * 16'(gain);
    shr  = prod >> 7;
    return (shr > 16'd255) ? 8'hFF : shr[7:0];
  endfunction

endpackage

// File: rtl/zone_bank_scheduler_dpram.sv
// Simple dual-port zone RAM: two banks of N_ZONE bytes, bank bit is address MSB.
module zone_dpram #(
  parameter int unsigned N_ZONE = 360,
  parameter int unsigned ADDR_W = 9
) (
  input  logic            I_clk,
  input  logic            I_wr_en,
  input  logic [ADDR_W:0] I_wr_addr,
  input  logic [7:0]      I_wr_data,
  input  logic            I_rd_en,
  input  logic [ADDR_W:0] I_rd_addr,
  output logic [7:0]      O_rd_data
);

  localparam int unsigned DEPTH = 2 * N_ZONE;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];

  // Map {bank, zone} onto the packed 2*N_ZONE storage.
  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W:0] a);
    return a[ADDR_W] ? IDX_W'(N_ZONE + 32'(a[ADDR_W-1:0])) : IDX_W'(a[ADDR_W-1:0]);
  endfunction

  // Write port; callers only strobe in-range zones.
  always_ff @(posedge I_clk) begin
    if (I_wr_en) mem[to_idx(I_wr_addr)] <= I_wr_data;
  end

  // Registered read port; contents are never reset.
  always_ff @(posedge I_clk) begin
    if (I_rd_en) O_rd_data <= mem[to_idx(I_rd_addr)];
  end

endmodule

// File: rtl/zone_bank_scheduler.sv
// Ping-pong zone bank scheduler between a statistics writer and an LED driver reader.
module zone_bank_scheduler
  import zone_bank_scheduler_pkg::*;
#(
  parameter int unsigned N_ZONE   = ZBS_N_ZONE,
  parameter int unsigned GAIN_MIN = ZBS_GAIN_MIN
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_wr_en,
  input  logic [ZBS_ADDR_W-1:0] I_wr_addr,
  input  logic [7:0]            I_wr_data,
  input  logic                  I_wr_frame_done,
  input  logic                  I_rd_req,
  input  logic [ZBS_ADDR_W-1:0] I_rd_addr,
  input  logic                  I_rd_frame_done,
  input  logic [11:0]           I_bright_data,
  output logic                  O_rd_valid,
  output logic [7:0]            O_rd_data,
  output logic                  O_wr_bank,
  output logic                  O_rd_bank,
  output logic                  O_swap,
  output logic [7:0]            O_drop_cnt,
  output logic [1:0]            O_state
);

  zbs_state_e state_q, state_d;
  logic       swap_c, drop_c;
  logic       wr_ok_c, rd_ok_c, rd_in_range_c;
  logic       wr_bank_q, rd_bank_q, swap_q;
  logic [7:0] drop_cnt_q, gain_q, gain_s1_q;
  logic       rd_v1_q, rd_mask1_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q, ram_q;

  assign wr_ok_c       = I_wr_en && (32'(I_wr_addr) < N_ZONE);
  assign rd_in_range_c = 32'(I_rd_addr) < N_ZONE;
  assign rd_ok_c       = I_rd_req && rd_in_range_c;

  zone_dpram #(.N_ZONE(N_ZONE), .ADDR_W(ZBS_ADDR_W)) u_zone_dpram (
    .I_clk     (I_clk),
    .I_wr_en   (wr_ok_c),
    .I_wr_addr ({wr_bank_q, I_wr_addr}),
    .I_wr_data (I_wr_data),
    .I_rd_en   (rd_ok_c),
    .I_rd_addr ({rd_bank_q, I_rd_addr}),
    .O_rd_data (ram_q)
  );

  // FSM state register.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, swap and drop decisions from the two frame-done pulses.
  always_comb begin
    state_d = state_q;
    swap_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_wr_frame_done) begin
          swap_c  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (I_wr_frame_done && I_rd_frame_done) swap_c  = 1'b1;
        else if (I_wr_frame_done)               state_d = ST_WAIT_RD;
        else if (I_rd_frame_done)               state_d = ST_WAIT_WR;
      end
      ST_WAIT_RD: begin
        if (I_rd_frame_done) begin
          swap_c  = 1'b1;
          state_d = ST_RUN;
        end else if (I_wr_frame_done) begin
          drop_c  = 1'b1;
        end
      end
      ST_WAIT_WR: begin
        if (I_wr_frame_done) begin
          swap_c  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bank ownership, swap pulse, drop counter and per-frame gain latch.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      swap_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
      gain_q     <= ZBS_GAIN_RST;
    end else begin
      swap_q <= swap_c;
      if (swap_c) begin
        wr_bank_q <= ~wr_bank_q;
        rd_bank_q <= ~rd_bank_q;
        gain_q    <= gain_clamp(I_bright_data, 8'(GAIN_MIN));
      end
      if (drop_c && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Read pipeline: stage 1 alongside the RAM read, stage 2 scales and masks.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rd_v1_q    <= 1'b0;
      rd_mask1_q <= 1'b1;
      gain_s1_q  <= ZBS_GAIN_RST;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      rd_v1_q    <= I_rd_req;
      rd_mask1_q <= !rd_in_range_c || (state_q == ST_IDLE);
      gain_s1_q  <= gain_q;
      rd_valid_q <= rd_v1_q;
      rd_data_q  <= (rd_v1_q && !rd_mask1_q) ? zone_scale(ram_q, gain_s1_q) : 8'd0;
    end
  end

  assign O_rd_valid = rd_valid_q;
  assign O_rd_data  = rd_data_q;
  assign O_wr_bank  = wr_bank_q;
  assign O_rd_bank  = rd_bank_q;
  assign O_swap     = swap_q;
  assign O_drop_cnt = drop_cnt_q;
  assign O_state    = state_q;

endmodule

// File: tb/tb_zone_bank_scheduler.sv
// Randomized self-checking bench for zone_bank_scheduler against a frame-handshake model.
module tb_zone_bank_scheduler;

  localparam int N = 360;

  logic       I_clk, I_rst;
  logic       I_wr_en, I_wr_frame_done, I_rd_req, I_rd_frame_done;
  logic [8:0] I_wr_addr, I_rd_addr;
  logic [7:0] I_wr_data;
  logic [11:0] I_bright_data;
  logic       O_rd_valid, O_wr_bank, O_rd_bank, O_swap;
  logic [7:0] O_rd_data, O_drop_cnt;
  logic [1:0] O_state;

  zone_bank_scheduler dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr), .I_wr_data(I_wr_data),
    .I_wr_frame_done(I_wr_frame_done),
    .I_rd_req(I_rd_req), .I_rd_addr(I_rd_addr), .I_rd_frame_done(I_rd_frame_done),
    .I_bright_data(I_bright_data),
    .O_rd_valid(O_rd_valid), .O_rd_data(O_rd_data),
    .O_wr_bank(O_wr_bank), .O_rd_bank(O_rd_bank), .O_swap(O_swap),
    .O_drop_cnt(O_drop_cnt), .O_state(O_state)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: writer/reader handshake flags rather than an explicit FSM.
  int m_mem [2][N];
  bit m_started, m_wr_pending, m_rd_pending, m_rd_bank;
  int m_gain, m_drop;
  bit p_v;
  int p_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_state();
    if (!m_started)   return 0;
    if (m_wr_pending) return 2;
    if (m_rd_pending) return 3;
    return 1;
  endfunction

  task automatic clear_inputs();
    I_wr_en = 0; I_wr_addr = 0; I_wr_data = 0; I_wr_frame_done = 0;
    I_rd_req = 0; I_rd_addr = 0; I_rd_frame_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    I_rst = 1'b1;
    #3;
    m_started = 0; m_wr_pending = 0; m_rd_pending = 0; m_rd_bank = 1;
    m_gain = 128; m_drop = 0; p_v = 0; p_d = 0;
    chk("rst_state", 32'(O_state), 0);
    chk("rst_rd_bank", 32'(O_rd_bank), 1);
    chk("rst_wr_bank", 32'(O_wr_bank), 0);
    chk("rst_swap", 32'(O_swap), 0);
    chk("rst_drop", 32'(O_drop_cnt), 0);
    chk("rst_valid", 32'(O_rd_valid), 0);
    chk("rst_data", 32'(O_rd_data), 0);
    @(posedge I_clk); #1;
    I_rst = 1'b0;
  endtask

  // Apply current inputs for one clock, advance the model, compare all outputs.
  task automatic step();
    int rdat;
    bit sw, w, r;
    rdat = 0;
    if (I_rd_req && int'(I_rd_addr) < N && m_started) begin
      rdat = (m_mem[m_rd_bank ? 1 : 0][int'(I_rd_addr)] * m_gain) / 128;
      if (rdat > 255) rdat = 255;
    end
    if (I_wr_en && int'(I_wr_addr) < N)
      m_mem[m_rd_bank ? 0 : 1][int'(I_wr_addr)] = int'(I_wr_data);
    sw = 0;
    if (!m_started) begin
      if (I_wr_frame_done) begin sw = 1; m_started = 1; end
    end else begin
      w = m_wr_pending | I_wr_frame_done;
      r = m_rd_pending | I_rd_frame_done;
      if (w && r) begin
        sw = 1; m_wr_pending = 0; m_rd_pending = 0;
      end else begin
        if (m_wr_pending && I_wr_frame_done && m_drop < 255) m_drop++;
        m_wr_pending = w;
        m_rd_pending = r;
      end
    end
    if (sw) begin
      m_rd_bank = !m_rd_bank;
      m_gain = int'(I_bright_data) / 16;
      if (m_gain < 32) m_gain = 32;
    end
    @(posedge I_clk); #1;
    chk("state", 32'(O_state), 32'(m_state()));
    chk("rd_bank", 32'(O_rd_bank), 32'(m_rd_bank));
    chk("wr_bank", 32'(O_wr_bank), 32'(!m_rd_bank));
    chk("swap", 32'(O_swap), 32'(sw));
    chk("drop_cnt", 32'(O_drop_cnt), 32'(m_drop));
    chk("rd_valid", 32'(O_rd_valid), 32'(p_v));
    chk("rd_data", 32'(O_rd_data), 32'(p_d));
    p_v = I_rd_req;
    p_d = rdat;
  endtask

  task automatic fill_bank();
    for (int z = 0; z < N; z++) begin
      I_wr_en = 1; I_wr_addr = 9'(z);
      I_wr_data = (z == 5) ? 8'd200 : 8'($urandom_range(0, 255));
      step();
    end
    I_wr_en = 0;
  endtask

  task automatic read_one(input int addr, input int exp, input string tag);
    I_rd_req = 1; I_rd_addr = 9'(addr);
    step();
    I_rd_req = 0;
    chk({tag, "_early"}, 32'(O_rd_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(O_rd_valid), 1);
    chk(tag, 32'(O_rd_data), 32'(exp));
  endtask

  initial begin
    I_rst = 1'b0;
    I_bright_data = 12'h800;
    clear_inputs();
    #2;
    do_reset();

    // First frame: fill bank 0 while idle, then the first swap.
    fill_bank();
    I_bright_data = 12'h800; I_wr_frame_done = 1;
    step();
    I_wr_frame_done = 0;
    chk("first_swap", 32'(O_swap), 1);
    chk("first_rd_bank", 32'(O_rd_bank), 0);
    chk("first_state", 32'(O_state), 1);

    fill_bank();
    read_one(5, 200, "rd5_gain128");

    // Simultaneous frame-done in RUN: one swap, no drop, saturated gain.
    I_bright_data = 12'hFFF; I_wr_frame_done = 1; I_rd_frame_done = 1;
    step();
    I_wr_frame_done = 0; I_rd_frame_done = 0;
    chk("both_swap", 32'(O_swap), 1);
    chk("both_state", 32'(O_state), 1);
    chk("both_drop", 32'(O_drop_cnt), 0);
    read_one(5, 255, "rd5_sat");

    // Writer outruns reader: two dropped frames, one swap on reader done.
    I_bright_data = 12'h010;
    for (int i = 0; i < 3; i++) begin
      I_wr_frame_done = 1; step();
      I_wr_frame_done = 0; step();
    end
    chk("drop2", 32'(O_drop_cnt), 2);
    chk("wait_rd_state", 32'(O_state), 2);
    I_rd_frame_done = 1; step();
    I_rd_frame_done = 0;
    chk("drop_swap", 32'(O_swap), 1);
    step();
    chk("drop_swap_once", 32'(O_swap), 0);

    // Out-of-range read and write, gain floor.
    I_wr_en = 1; I_wr_addr = 9'd400; I_wr_data = 8'd77;
    read_one(360, 0, "rd360");
    I_wr_en = 0;
    read_one(5, 50, "rd5_gain32");

    // Randomized traffic with occasional mid-frame resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      I_wr_en = 1'($urandom_range(0, 1));
      I_wr_addr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(360, 511)) : 9'($urandom_range(0, 359));
      I_wr_data = 8'($urandom_range(0, 255));
      I_wr_frame_done = ($urandom_range(0, 15) == 0);
      I_rd_req = 1'($urandom_range(0, 1));
      I_rd_addr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(360, 511)) : 9'($urandom_range(0, 359));
      I_rd_frame_done = ($urandom_range(0, 15) == 0);
      I_bright_data = 12'($urandom_range(0, 4095));
      step();
    end
    clear_inputs();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
